// File: rtl/goertzel_tone_gen_pkg.sv
// Shared definitions for the Goertzel test-tone generator.
//   FRAC_DEF            default fractional bits of the Q2.30 coefficient
//   ONE_Q30, ZERO_COEFF handy coefficients (2cos(60deg) = 1.0, 2cos(90deg) = 0)
//   SAT_MAX / SAT_MIN   32-bit signed clamp limits (plus 34-bit copies for compares)
//   state_t             generator FSM encoding
//   sat34, neg_sat32    clamp helpers shared by the datapath and the control
`timescale 1ns/1ps
package goertzel_tone_gen_pkg;

  localparam int FRAC_DEF = 30;

  localparam logic signed [31:0] ONE_Q30    = 32'sh4000_0000;
  localparam logic signed [31:0] ZERO_COEFF = 32'sh0000_0000;

  localparam logic signed [31:0] SAT_MAX   = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN   = 32'sh8000_0000;
  localparam logic signed [33:0] SAT_MAX34 = 34'sd2147483647;
  localparam logic signed [33:0] SAT_MIN34 = -34'sd2147483648;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_MUL1 = 3'd2,
    S_MUL2 = 3'd3,
    S_UPD  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // Clamp a 34-bit signed intermediate into the 32-bit signed sample range.
  function automatic logic signed [31:0] sat34(input logic signed [33:0] v);
    if (v > SAT_MAX34) return SAT_MAX;
    else if (v < SAT_MIN34) return SAT_MIN;
    else return v[31:0];
  endfunction

  // Saturating negate: -(-2^31) becomes 2^31-1 instead of wrapping.
  function automatic logic signed [31:0] neg_sat32(input logic signed [31:0] v);
    return sat34(-34'(v));
  endfunction

endpackage

// File: rtl/goertzel_tone_gen_if.sv
// Bus between the tone generator and whoever drives it.
//   master modport: drives sample_tick, start, coeff, init_y1; observes results
//   slave  modport: the generator itself
// Handshake: strobe based, no back-pressure. start and sample_tick are one-cycle
// pulses the generator must take when they occur (start only while idle, ticks
// only in WAIT); sample_valid is a one-cycle pulse qualifying sample, and done is
// a one-cycle pulse after the last sample. state_dbg mirrors the FSM state.
`timescale 1ns/1ps
interface goertzel_tone_gen_if;
  logic                          sample_tick;
  logic                          start;
  logic signed [31:0]            coeff;
  logic signed [31:0]            init_y1;
  logic signed [31:0]            sample;
  logic                          sample_valid;
  logic                          busy;
  logic                          done;
  logic                          overrun;
  goertzel_tone_gen_pkg::state_t state_dbg;

  modport master (
    output sample_tick, start, coeff, init_y1,
    input  sample, sample_valid, busy, done, overrun, state_dbg
  );

  modport slave (
    input  sample_tick, start, coeff, init_y1,
    output sample, sample_valid, busy, done, overrun, state_dbg
  );
endinterface

// File: rtl/goertzel_tone_gen_mac.sv
// tone_mac: one step of the recurrence y_next = sat32(rnd(coeff*y_cur) - y_prev).
//   clock, reset_n       clock and asynchronous active-low reset
//   in_valid             operands are captured this cycle
//   coeff, y_cur, y_prev Q2.30 coefficient and the two previous samples
//   out_valid, y_next    result qualifier and saturated next sample
// Three register stages: operands, 64-bit product, rounded 34-bit value. The
// subtract and clamp after the last register are combinational so the control
// can commit y_next at the end of the cycle in which out_valid is high.
`timescale 1ns/1ps
module tone_mac
  import goertzel_tone_gen_pkg::*;
#(
  parameter int FRAC = FRAC_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic signed [31:0] coeff,
  input  logic signed [31:0] y_cur,
  input  logic signed [31:0] y_prev,
  output logic               out_valid,
  output logic signed [31:0] y_next
);

  localparam logic signed [63:0] RND = 64'sd1 <<< (FRAC - 1);

  logic               v0, v1, v2;
  logic signed [31:0] c0, y0, yp0, yp1, yp2;
  logic signed [63:0] p1;
  logic signed [33:0] r2;
  logic signed [33:0] diff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v0  <= 1'b0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      c0  <= '0;
      y0  <= '0;
      yp0 <= '0;
      yp1 <= '0;
      yp2 <= '0;
      p1  <= '0;
      r2  <= '0;
    end else begin
      v0  <= in_valid;
      c0  <= coeff;
      y0  <= y_cur;
      yp0 <= y_prev;

      v1  <= v0;
      p1  <= 64'(c0) * 64'(y0);
      yp1 <= yp0;

      // Round half up: add 2^(FRAC-1) then floor-shift. |p1| <= 2^62, so the
      // shifted value fits easily in 34 signed bits.
      v2  <= v1;
      r2  <= 34'((p1 + RND) >>> FRAC);
      yp2 <= yp1;
    end
  end

  assign diff      = r2 - 34'(yp2);
  assign y_next    = sat34(diff);
  assign out_valid = v2;

endmodule

// File: rtl/goertzel_tone_gen.sv
// goertzel_tone_gen: emits a burst of N_SAMPLES sine samples s[n] =
// sat32(rnd(coeff*s[n-1]) - s[n-2]), s[0]=0, s[1]=init_y1, one per sample_tick.
//   clock, reset_n  system clock, asynchronous active-low reset
//   bus (slave)     start/coeff/init_y1/sample_tick in; sample, sample_valid,
//                   busy, done, overrun, state_dbg out
// A tick while the next sample is still being computed (MUL1/MUL2/UPD) is
// dropped and sets the sticky overrun flag.
`timescale 1ns/1ps
module goertzel_tone_gen
  import goertzel_tone_gen_pkg::*;
#(
  parameter int N_SAMPLES = 520,
  parameter int FRAC      = FRAC_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  goertzel_tone_gen_if.slave  bus
);

  localparam int                CNT_W = (N_SAMPLES > 2) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N_SAMPLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic signed [31:0] coeff_r;
  logic signed [31:0] y_cur;
  logic signed [31:0] y_prev;
  logic signed [31:0] sample_r;
  logic               sample_valid_r;
  logic               busy_r;
  logic               done_r;
  logic               overrun_r;

  logic               mac_in_valid;
  logic               mac_out_valid;
  logic signed [31:0] mac_y;

  // Operands are captured on the accepted tick, so the result is ready in UPD.
  assign mac_in_valid = (state == S_WAIT) && bus.sample_tick;

  tone_mac #(.FRAC(FRAC)) u_mac (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (mac_in_valid),
    .coeff     (coeff_r),
    .y_cur     (y_cur),
    .y_prev    (y_prev),
    .out_valid (mac_out_valid),
    .y_next    (mac_y)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      coeff_r        <= '0;
      y_cur          <= '0;
      y_prev         <= '0;
      sample_r       <= '0;
      sample_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      sample_valid_r <= 1'b0;
      done_r         <= 1'b0;
      case (state)
        S_IDLE: begin
          // A simultaneous tick is deliberately not sampled here.
          if (bus.start) begin
            coeff_r   <= bus.coeff;
            y_cur     <= '0;
            // s[-1] = -s[1] makes the first recurrence step produce init_y1.
            y_prev    <= neg_sat32(bus.init_y1);
            cnt       <= '0;
            overrun_r <= 1'b0;
            busy_r    <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.sample_tick) begin
            sample_r       <= y_cur;
            sample_valid_r <= 1'b1;
            cnt            <= cnt + 1'b1;
            state          <= (cnt == LAST) ? S_FIN : S_MUL1;
          end
        end
        S_MUL1: begin
          if (bus.sample_tick) overrun_r <= 1'b1;
          state <= S_MUL2;
        end
        S_MUL2: begin
          if (bus.sample_tick) overrun_r <= 1'b1;
          state <= S_UPD;
        end
        S_UPD: begin
          if (bus.sample_tick) overrun_r <= 1'b1;
          if (mac_out_valid) begin
            y_prev <= y_cur;
            y_cur  <= mac_y;
          end
          state <= S_WAIT;
        end
        S_FIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.sample       = sample_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.overrun      = overrun_r;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// Bench for goertzel_tone_gen: a short-burst instance (N=8) and a full-length
// instance (N=520) share one set of stimulus signals, steered by sel.
`timescale 1ns/1ps
module tb_goertzel_tone_gen;
  import goertzel_tone_gen_pkg::*;

  localparam int N_A = 8;
  localparam int N_B = 520;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #4 clock = ~clock;

  // ---------------- shared stimulus ----------------
  logic        sel      = 1'b0;
  logic        tick     = 1'b0;
  logic        start    = 1'b0;
  logic [31:0] coeff_in = '0;
  logic [31:0] init_in  = '0;

  goertzel_tone_gen_if if_a ();
  goertzel_tone_gen_if if_b ();

  assign if_a.sample_tick = tick & ~sel;
  assign if_a.start       = start & ~sel;
  assign if_a.coeff       = coeff_in;
  assign if_a.init_y1     = init_in;
  assign if_b.sample_tick = tick & sel;
  assign if_b.start       = start & sel;
  assign if_b.coeff       = coeff_in;
  assign if_b.init_y1     = init_in;

  goertzel_tone_gen #(.N_SAMPLES(N_A)) dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a));
  goertzel_tone_gen #(.N_SAMPLES(N_B)) dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b));

  logic        mon_valid, mon_busy, mon_done, mon_over;
  logic [31:0] mon_sample;
  assign mon_valid  = sel ? if_b.sample_valid : if_a.sample_valid;
  assign mon_busy   = sel ? if_b.busy         : if_a.busy;
  assign mon_done   = sel ? if_b.done         : if_a.done;
  assign mon_over   = sel ? if_b.overrun      : if_a.overrun;
  assign mon_sample = sel ? if_b.sample       : if_a.sample;

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  int          n_emit   = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (mon_valid) begin
        n_emit++;
        got_q.push_back(mon_sample);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sample actual=%h required=none", mon_sample);
        end else begin
          check("sample", mon_sample, exp_q.pop_front());
        end
      end
      if (mon_done) begin
        done_cnt++;
        check("busy_low_with_done", 32'(mon_busy), 32'd0);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Sine recurrence in plain integer arithmetic: Q2.30 multiply, round half up.
  task automatic push_model(input logic [31:0] c, input logic [31:0] i, input int n);
    longint s2 = 0;
    longint s1 = 0;
    longint s  = 0;
    longint prod;
    for (int k = 0; k < n; k++) begin
      if (k == 0) s = 0;
      else if (k == 1) s = longint'($signed(i));
      else begin
        prod = longint'($signed(c)) * s1;
        s = clamp32(((prod + 64'sd536870912) >>> 30) - s2);
      end
      exp_q.push_back(s[31:0]);
      s2 = s1;
      s1 = s;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] c, input logic [31:0] i);
    start    = 1'b1;
    coeff_in = c;
    init_in  = i;
    cycles(1);
    start    = 1'b0;
  endtask

  task automatic tick_gap(input int gap);
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    if (gap > 1) cycles(gap - 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel;
    logic [31:0] coeff;
    logic [31:0] init;
    int          gap_lo;
    int          gap_hi;
    logic        hand;
    logic [31:0] e1, e2, e3;
  } vec_t;

  vec_t vt[6];

  task automatic run_burst(input vec_t v, input string tag);
    int n;
    int d0;
    sel = v.sel;
    n   = v.sel ? N_B : N_A;
    got_q.delete();
    n_emit = 0;
    d0     = done_cnt;
    push_model(v.coeff, v.init, n);
    pulse_start(v.coeff, v.init);
    check({tag, "_busy_after_start"}, 32'(mon_busy), 32'd1);
    for (int k = 0; k < n; k++) tick_gap(int'($urandom_range(v.gap_hi, v.gap_lo)));
    cycles(6);
    check({tag, "_emitted"}, 32'(n_emit), 32'(n));
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_end"}, 32'(mon_busy), 32'd0);
    check({tag, "_no_overrun"}, 32'(mon_over), 32'd0);
    if (v.hand && got_q.size() > 3) begin
      check({tag, "_s1"}, got_q[1], v.e1);
      check({tag, "_s2"}, got_q[2], v.e2);
      check({tag, "_s3"}, got_q[3], v.e3);
    end
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;

    vt[0] = '{1'b0, ZERO_COEFF,    32'd1000,       4, 4, 1'b1, 32'd1000, 32'd0, -32'sd1000};
    vt[1] = '{1'b1, ONE_Q30,       32'd5000,       4, 5, 1'b1, 32'd5000, 32'd5000, 32'd0};
    vt[2] = '{1'b1, 32'h7FFF_FFFF, 32'h7000_0000,  4, 4, 1'b1, 32'h7000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vt[3] = '{1'b1, $urandom(), $urandom_range(32'h3FFF_FFFF, 0) - 32'h2000_0000, 4, 7, 1'b0, 0, 0, 0};
    vt[4] = '{1'b1, $urandom(), $urandom_range(32'h0FFF_FFFF, 0) - 32'h0800_0000, 4, 6, 1'b0, 0, 0, 0};
    vt[5] = '{1'b0, $urandom(), $urandom_range(32'h3FFF_FFFF, 0) - 32'h2000_0000, 4, 9, 1'b0, 0, 0, 0};

    // Reset state.
    reset_n = 1'b0;
    cycles(3);
    check("rst_a_sample",  if_a.sample, 32'd0);
    check("rst_a_valid",   32'(if_a.sample_valid), 32'd0);
    check("rst_a_busy",    32'(if_a.busy), 32'd0);
    check("rst_a_done",    32'(if_a.done), 32'd0);
    check("rst_a_overrun", 32'(if_a.overrun), 32'd0);
    check("rst_b_busy",    32'(if_b.busy), 32'd0);
    check("rst_b_state",   32'(if_b.state_dbg), 32'(S_IDLE));
    reset_n = 1'b1;
    cycles(2);

    for (int t = 0; t < 6; t++) run_burst(vt[t], $sformatf("vec%0d", t));

    // Ticks two clocks apart: every other tick lands in MUL2 and is dropped.
    sel = 1'b0;
    got_q.delete();
    n_emit = 0;
    d0 = done_cnt;
    push_model(ONE_Q30, 32'd300, N_A);
    pulse_start(ONE_Q30, 32'd300);
    for (int k = 0; k < N_A; k++) begin
      if (k < 3) begin
        tick_gap(2);
        tick_gap(2);
      end else begin
        tick_gap(4);
      end
    end
    cycles(6);
    check("ovr_flag", 32'(mon_over), 32'd1);
    check("ovr_emitted", 32'(n_emit), 32'(N_A));
    check("ovr_done_once", 32'(done_cnt - d0), 32'd1);
    check("ovr_queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // start together with a tick in IDLE, then a start while busy.
    got_q.delete();
    n_emit = 0;
    d0 = done_cnt;
    push_model(ONE_Q30, 32'd777, N_A);
    start = 1'b1;
    tick = 1'b1;
    coeff_in = ONE_Q30;
    init_in = 32'd777;
    cycles(1);
    start = 1'b0;
    tick = 1'b0;
    check("start_clears_overrun", 32'(mon_over), 32'd0);
    cycles(4);
    check("no_sample_on_start_tick", 32'(n_emit), 32'd0);
    tick_gap(4);
    tick_gap(4);
    pulse_start(32'h7FFF_FFFF, 32'h1234_5678);
    cycles(2);
    for (int k = 2; k < N_A; k++) tick_gap(4);
    cycles(6);
    check("busy_start_emitted", 32'(n_emit), 32'(N_A));
    check("busy_start_done_once", 32'(done_cnt - d0), 32'd1);
    check("busy_start_queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset at sample 100 of 520 aborts the burst without done.
    sel = 1'b1;
    got_q.delete();
    n_emit = 0;
    push_model(32'h7E00_0000, 32'h0100_0000, 100);
    pulse_start(32'h7E00_0000, 32'h0100_0000);
    for (int k = 0; k < 100; k++) tick_gap(4);
    check("mid_burst_busy", 32'(if_b.busy), 32'd1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("async_rst_sample",  if_b.sample, 32'd0);
    check("async_rst_valid",   32'(if_b.sample_valid), 32'd0);
    check("async_rst_busy",    32'(if_b.busy), 32'd0);
    check("async_rst_overrun", 32'(if_b.overrun), 32'd0);
    check("async_rst_state",   32'(if_b.state_dbg), 32'(S_IDLE));
    cycles(3);
    reset_n = 1'b1;
    cycles(10);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_emitted", 32'(n_emit), 32'd100);
    check("abort_queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    n_emit = 0;
    exp_q.push_back(32'd0);
    pulse_start(32'h7E00_0000, 32'h0100_0000);
    tick_gap(4);
    check("restart_first_sample_seen", 32'(n_emit), 32'd1);
    check("restart_queue_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
